// File: rtl/pll_seq_pkg.sv
// Shared types and default constants for the PLL lock sequencer.
package pll_seq_pkg;

  // Sequencer states; the encoding is also exported on the debug state port.
  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StLoad    = 3'd1,
    StAcquire = 3'd2,
    StTrack   = 3'd3,
    StFault   = 3'd4
  } state_e;

  localparam logic [31:0] DefaultFreq = 32'h9C40;  // 40 kHz start word
  localparam logic [31:0] RetryStep   = 32'h32;
  localparam logic [4:0]  LgAcq       = 5'd10;
  localparam logic [4:0]  LgTrack     = 5'd13;

endpackage

// File: rtl/pll_lock_detector.sv
// Windowed lock detector: counts large-error cycles over a fixed window and
// reports at the last cycle of each window whether the window was good.
module pll_lock_detector #(
  parameter int unsigned LOCK_WINDOW = 256,
  parameter int unsigned LOCK_THRESH = 4
) (
  input  logic clk,
  input  logic nrst,
  input  logic clear,
  input  logic err_big,
  output logic window_done,
  output logic window_good
);

  localparam int unsigned WinW   = $clog2(LOCK_WINDOW);
  localparam int unsigned ErrMax = LOCK_THRESH + 1;  // one past threshold is enough to fail
  localparam int unsigned ErrW   = $clog2(ErrMax + 1);

  logic [WinW-1:0] win_q, win_d;
  logic [ErrW-1:0] err_q, err_d, err_sum;

  // Window position, error total including this cycle, and next-state counters.
  always_comb begin
    err_sum = err_q;
    if (err_big && (err_q != ErrW'(ErrMax))) begin
      err_sum = err_q + 1'b1;
    end
    window_done = (win_q == WinW'(LOCK_WINDOW - 1));
    window_good = (err_sum <= ErrW'(LOCK_THRESH));
    if (clear || window_done) begin
      win_d = '0;
      err_d = '0;
    end else begin
      win_d = win_q + 1'b1;
      err_d = err_sum;
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      win_q <= '0;
      err_q <= '0;
    end else begin
      win_q <= win_d;
      err_q <= err_d;
    end
  end

endmodule

// File: rtl/pll_lock_sequencer.sv
// Sequences the SWIPT receive PLL from frequency load through acquisition to
// tracking, retrying at offset start frequencies and flagging a fault.
// Build option: define LOCK_RETRY_EN to enable retries at offset frequencies;
// without it an acquisition timeout goes straight to FAULT.
module pll_lock_sequencer
  import pll_seq_pkg::*;
#(
  parameter logic [31:0] DEFAULT_FREQ = DefaultFreq,
`ifdef LOCK_RETRY_EN
  parameter logic [31:0] RETRY_STEP   = RetryStep,
  parameter int unsigned MAX_RETRY    = 3,
`endif
  parameter int unsigned LOAD_CYCLES  = 16,
  parameter int unsigned LOCK_WINDOW  = 256,
  parameter int unsigned LOCK_THRESH  = 4,
  parameter int unsigned ACQ_TIMEOUT  = 65536,
  parameter logic [4:0]  LG_ACQ       = LgAcq,
  parameter logic [4:0]  LG_TRACK     = LgTrack
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        swipt_alive,
  input  logic        adc_comp,
  input  logic [1:0]  pll_error,
  output logic        load_freq,
  output logic [31:0] freq,
  output logic [4:0]  lgcoefficient,
  output logic        pll_in,
  output logic        locked,
  output logic        fault,
  output logic [2:0]  state
);

  // Dwell counter shared by LOAD and ACQUIRE; cleared on every state entry.
  localparam int unsigned CntW = $clog2(ACQ_TIMEOUT);
  localparam logic [CntW-1:0] CntMax = CntW'(ACQ_TIMEOUT - 1);

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            good_q, good_d;  // previous window in ACQUIRE was good
  logic            clear, window_done, window_good, load_done, acq_timeout;
  logic            load_freq_q, load_freq_d, pll_in_q, pll_in_d;
  logic            locked_q, locked_d, fault_q, fault_d;
  logic [31:0]     freq_q, freq_d;
  logic [4:0]      lg_q, lg_d;
`ifdef LOCK_RETRY_EN
  localparam int unsigned RetryW = $clog2(MAX_RETRY + 1);
  logic [RetryW-1:0] retry_q, retry_d;
`endif

  pll_lock_detector #(
    .LOCK_WINDOW(LOCK_WINDOW),
    .LOCK_THRESH(LOCK_THRESH)
  ) u_detector (
    .clk        (clk),
    .nrst       (nrst),
    .clear      (clear),
    .err_big    (pll_error[1]),
    .window_done(window_done),
    .window_good(window_good)
  );

  assign load_done   = (cnt_q == CntW'(LOAD_CYCLES - 1));
  assign acq_timeout = (cnt_q == CntMax);

  // Next state; a dropped link overrides every other transition.
  always_comb begin
    state_d = state_q;
`ifdef LOCK_RETRY_EN
    retry_d = retry_q;
`endif
    unique case (state_q)
      StIdle:    if (swipt_alive) state_d = StLoad;
      StLoad:    if (load_done) state_d = StAcquire;
      StAcquire: begin
        // A completed second good window beats a coincident timeout.
        if (window_done && window_good && good_q) begin
          state_d = StTrack;
        end else if (acq_timeout) begin
`ifdef LOCK_RETRY_EN
          if (retry_q < RetryW'(MAX_RETRY)) begin
            retry_d = retry_q + 1'b1;
            state_d = StLoad;
          end else begin
            state_d = StFault;
          end
`else
          state_d = StFault;
`endif
        end
      end
      StTrack:   if (window_done && !window_good) state_d = StAcquire;
      StFault:   state_d = StFault;
      default:   state_d = StIdle;
    endcase
    if (!swipt_alive) state_d = StIdle;
`ifdef LOCK_RETRY_EN
    if (state_d == StIdle) retry_d = '0;
`endif
  end

  // Counter and lock-history bookkeeping, restarted on every state entry.
  always_comb begin
    clear  = (state_d != state_q);
    cnt_d  = cnt_q;
    good_d = good_q;
    if (clear) begin
      cnt_d  = '0;
      good_d = 1'b0;
    end else begin
      if (cnt_q != CntMax) cnt_d = cnt_q + 1'b1;
      if (window_done) good_d = window_good;
    end
  end

  // Registered outputs follow the state being entered.
  always_comb begin
    load_freq_d = (state_d == StIdle) || (state_d == StLoad) || (state_d == StFault);
    locked_d    = (state_d == StTrack);
    fault_d     = (state_d == StFault);
    lg_d        = (state_d == StTrack) ? LG_TRACK : LG_ACQ;
    pll_in_d    = ((state_q == StAcquire) || (state_q == StTrack)) ? pll_error[0] : adc_comp;
    freq_d      = freq_q;
    if (state_d == StIdle) begin
      freq_d = DEFAULT_FREQ;
    end else if (state_d == StLoad) begin
`ifdef LOCK_RETRY_EN
      freq_d = DEFAULT_FREQ + RETRY_STEP * 32'(retry_d);
`else
      freq_d = DEFAULT_FREQ;
`endif
    end
  end

  // State, counters and output registers.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      good_q      <= 1'b0;
      load_freq_q <= 1'b1;
      freq_q      <= DEFAULT_FREQ;
      lg_q        <= LG_ACQ;
      pll_in_q    <= 1'b0;
      locked_q    <= 1'b0;
      fault_q     <= 1'b0;
`ifdef LOCK_RETRY_EN
      retry_q     <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      good_q      <= good_d;
      load_freq_q <= load_freq_d;
      freq_q      <= freq_d;
      lg_q        <= lg_d;
      pll_in_q    <= pll_in_d;
      locked_q    <= locked_d;
      fault_q     <= fault_d;
`ifdef LOCK_RETRY_EN
      retry_q     <= retry_d;
`endif
    end
  end

  assign load_freq     = load_freq_q;
  assign freq          = freq_q;
  assign lgcoefficient = lg_q;
  assign pll_in        = pll_in_q;
  assign locked        = locked_q;
  assign fault         = fault_q;
  assign state         = state_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Self-checking bench for pll_lock_sequencer with a behavioural reference model.
// Acquisition timeout is shortened so the retry path completes quickly.
module tb_pll_lock_sequencer;
  import pll_seq_pkg::*;

  localparam int unsigned AcqT = 2048;
  localparam int unsigned Win  = 256;
  localparam logic [31:0] Def  = 32'h9C40;
  localparam logic [31:0] Step = 32'h32;
  localparam logic [43:0] ResetOuts = {StIdle, 1'b1, 32'h9C40, 5'd10, 3'b000};
`ifdef LOCK_RETRY_EN
  localparam bit RetryOn = 1'b1;
`else
  localparam bit RetryOn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        swipt_alive = 1'b0;
  logic        adc_comp = 1'b0;
  logic [1:0]  pll_error = 2'b00;
  logic        load_freq, pll_in, locked, fault;
  logic [31:0] freq;
  logic [4:0]  lgcoefficient;
  logic [2:0]  state;
  logic [43:0] outs;

  int checks = 0;
  int failures = 0;

  // Reference model state: phase, cycles spent in it, errors in current window,
  // consecutive good windows, retries used, and expected registered outputs.
  state_e      m_st;
  int unsigned m_age, m_errs, m_goods, m_retry;
  logic        e_load, e_pll_in, e_locked, e_fault;
  logic [31:0] e_freq;
  logic [4:0]  e_lg;

  pll_lock_sequencer #(.ACQ_TIMEOUT(AcqT)) dut (
    .clk          (clk),
    .nrst         (nrst),
    .swipt_alive  (swipt_alive),
    .adc_comp     (adc_comp),
    .pll_error    (pll_error),
    .load_freq    (load_freq),
    .freq         (freq),
    .lgcoefficient(lgcoefficient),
    .pll_in       (pll_in),
    .locked       (locked),
    .fault        (fault),
    .state        (state)
  );

  always #5 clk = ~clk;
  assign outs = {state, load_freq, freq, lgcoefficient, pll_in, locked, fault};

  function automatic logic [43:0] model_outs();
    return {m_st, e_load, e_freq, e_lg, e_pll_in, e_locked, e_fault};
  endfunction

  task automatic model_reset();
    m_st = StIdle; m_age = 0; m_errs = 0; m_goods = 0; m_retry = 0;
    e_load = 1'b1; e_freq = Def; e_lg = 5'd10; e_pll_in = 1'b0;
    e_locked = 1'b0; e_fault = 1'b0;
  endtask

  // One clock of the sequencing rules, from the inputs present at the edge.
  task automatic model_step();
    state_e nx;
    int unsigned nr, tot;
    bit wend, good, in_lock;
    in_lock  = (m_st == StAcquire) || (m_st == StTrack);
    e_pll_in = in_lock ? pll_error[0] : adc_comp;
    wend     = in_lock && ((m_age % Win) == Win - 1);
    tot      = m_errs + int'(pll_error[1]);
    good     = (tot <= 4);
    nx = m_st;
    nr = m_retry;
    case (m_st)
      StIdle:    if (swipt_alive) nx = StLoad;
      StLoad:    if (m_age == 15) nx = StAcquire;
      StAcquire: begin
        if (wend && good && m_goods >= 1) nx = StTrack;
        else if (m_age == AcqT - 1) begin
          if (RetryOn && m_retry < 3) begin nr = m_retry + 1; nx = StLoad; end
          else nx = StFault;
        end
      end
      StTrack:   if (wend && !good) nx = StAcquire;
      default:   nx = m_st;
    endcase
    if (!swipt_alive) nx = StIdle;
    if (nx == StIdle) nr = 0;
    if (wend) begin m_goods = good ? m_goods + 1 : 0; m_errs = 0; end
    else m_errs = tot;
    if (nx != m_st) begin m_age = 0; m_errs = 0; m_goods = 0; end
    else m_age++;
    m_st = nx;
    m_retry = nr;
    e_load   = (nx == StIdle) || (nx == StLoad) || (nx == StFault);
    e_locked = (nx == StTrack);
    e_fault  = (nx == StFault);
    e_lg     = (nx == StTrack) ? 5'd13 : 5'd10;
    if (nx == StIdle) e_freq = Def;
    else if (nx == StLoad) e_freq = Def + Step * nr;
  endtask

  // Advance one clock; afterwards outputs are stable and inputs may be driven.
  task automatic tick();
    @(posedge clk);
    if (!nrst) model_reset();
    else model_step();
    #1;
  endtask

  task automatic test_reset();
    logic last;
    nrst = 1'b0; swipt_alive = 1'b0; adc_comp = 1'b0; pll_error = 2'b00;
    model_reset();
    tick(); tick();
    checks++;
    if (outs !== ResetOuts) begin
      failures++; $display("FAIL reset_values got=%h exp=%h", outs, ResetOuts);
    end
    nrst = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      adc_comp = 1'($urandom);
      last = adc_comp;
      tick();
      checks++;
      if (state !== StIdle || load_freq !== 1'b1 || freq !== 32'h9C40) begin
        failures++;
        $display("FAIL idle_hold cyc=%0d got=%0d/%b/%h exp=0/1/9c40", i, state, load_freq, freq);
      end
      checks++;
      if (pll_in !== last) begin
        failures++; $display("FAIL idle_pll_in cyc=%0d got=%b exp=%b", i, pll_in, last);
      end
    end
  endtask

  task automatic test_lock();
    int cyc = 0, t_load = -1, t_acq = -1, t_lock = -1;
    logic [4:0] lg_before = 5'd0;
    swipt_alive = 1'b1;
    while (locked !== 1'b1 && cyc < 2000) begin
      pll_error = {1'b0, 1'($urandom)};
      adc_comp  = 1'($urandom);
      lg_before = lgcoefficient;
      tick();
      cyc++;
      if (t_load < 0 && state === StLoad) t_load = cyc;
      if (t_acq < 0 && t_load >= 0 && load_freq === 1'b0) t_acq = cyc;
      if (locked === 1'b1) t_lock = cyc;
      checks++;
      if (outs !== model_outs()) begin
        failures++; $display("FAIL lock_trace cyc=%0d got=%h exp=%h", cyc, outs, model_outs());
      end
    end
    checks++;
    if (t_load != 1) begin failures++; $display("FAIL load_entry got=%0d exp=1", t_load); end
    checks++;
    if (t_acq - t_load != 16) begin
      failures++; $display("FAIL load_len got=%0d exp=16", t_acq - t_load);
    end
    checks++;
    if (t_lock < 0 || t_lock - t_acq != 512) begin
      failures++; $display("FAIL lock_time got=%0d exp=512", t_lock - t_acq);
    end
    checks++;
    if (lg_before !== 5'd10 || lgcoefficient !== 5'd13) begin
      failures++; $display("FAIL lg_switch got=%0d->%0d exp=10->13", lg_before, lgcoefficient);
    end
  endtask

  task automatic test_unlock();
    int k = 0;
    int wait_n = $urandom_range(0, 100);
    while (locked === 1'b1 && k < 600) begin
      pll_error = {(k >= wait_n && k < wait_n + 5), 1'($urandom)};
      tick();
      k++;
      checks++;
      if (outs !== model_outs()) begin
        failures++; $display("FAIL unlock_trace k=%0d got=%h exp=%h", k, outs, model_outs());
      end
    end
    checks++;
    if (k != 256 || state !== StAcquire || locked !== 1'b0 || lgcoefficient !== 5'd10) begin
      failures++;
      $display("FAIL unlock k=%0d st=%0d lk=%b lg=%0d exp 256/2/0/10", k, state, locked,
               lgcoefficient);
    end
  endtask

  // Six bad windows then two good ones: the second good window lands on the timeout.
  task automatic test_timeout_tie();
    for (int i = 0; i < int'(AcqT); i++) begin
      pll_error = {(i < 6 * int'(Win)), 1'($urandom)};
      tick();
      checks++;
      if (outs !== model_outs()) begin
        failures++; $display("FAIL tie_trace i=%0d got=%h exp=%h", i, outs, model_outs());
      end
    end
    checks++;
    if (state !== StTrack || locked !== 1'b1) begin
      failures++; $display("FAIL tie_wins got=%0d/%b exp=3/1", state, locked);
    end
  endtask

  task automatic test_retry();
    logic [31:0] seen[$];
    logic [31:0] expf[$];
    logic [2:0]  prev;
    int k = 0;
    prev = state;
    pll_error = 2'b10;
    while (fault !== 1'b1 && k < 10000) begin
      pll_error[0] = 1'($urandom);
      tick();
      k++;
      if (state === StLoad && prev !== StLoad) seen.push_back(freq);
      prev = state;
      checks++;
      if (outs !== model_outs()) begin
        failures++; $display("FAIL retry_trace k=%0d got=%h exp=%h", k, outs, model_outs());
      end
    end
    if (RetryOn) for (int r = 1; r <= 3; r++) expf.push_back(Def + Step * r);
    checks++;
    if (seen.size() != expf.size()) begin
      failures++; $display("FAIL retry_count got=%0d exp=%0d", seen.size(), expf.size());
    end
    for (int r = 0; r < expf.size() && r < seen.size(); r++) begin
      checks++;
      if (seen[r] !== expf[r]) begin
        failures++; $display("FAIL retry_freq%0d got=%h exp=%h", r, seen[r], expf[r]);
      end
    end
    checks++;
    if (fault !== 1'b1 || state !== StFault || load_freq !== 1'b1) begin
      failures++; $display("FAIL fault_state got=%b/%0d/%b exp=1/4/1", fault, state, load_freq);
    end
  endtask

  task automatic test_drop();
    logic last;
    swipt_alive = 1'b0;
    tick();
    checks++;
    if (state !== StIdle || fault !== 1'b0 || load_freq !== 1'b1 || freq !== Def) begin
      failures++; $display("FAIL drop_fault got=%0d/%b/%h exp=0/0/9c40", state, fault, freq);
    end
    adc_comp = 1'($urandom); last = adc_comp;
    tick();
    checks++;
    if (pll_in !== last) begin failures++; $display("FAIL idle_adc got=%b exp=%b", pll_in, last); end
    swipt_alive = 1'b1; pll_error = 2'b00;
    tick();
    checks++;
    if (state !== StLoad || freq !== Def) begin
      failures++; $display("FAIL reload_freq got=%0d/%h exp=1/9c40", state, freq);
    end
    for (int i = 0; i < 16 + 60; i++) begin
      pll_error = {1'b0, 1'($urandom)};
      adc_comp  = 1'($urandom);
      tick();
      checks++;
      if (outs !== model_outs()) begin
        failures++; $display("FAIL acq_trace i=%0d got=%h exp=%h", i, outs, model_outs());
      end
    end
    last = pll_error[0];
    tick();
    checks++;
    if (state !== StAcquire || pll_in !== last) begin
      failures++; $display("FAIL acq_pll_in got=%0d/%b exp=2/%b", state, pll_in, last);
    end
    swipt_alive = 1'b0;
    tick();
    checks++;
    if (state !== StIdle || load_freq !== 1'b1) begin
      failures++; $display("FAIL drop_acq got=%0d/%b exp=0/1", state, load_freq);
    end
    adc_comp = ~pll_error[0]; last = adc_comp;
    tick();
    checks++;
    if (pll_in !== last) begin failures++; $display("FAIL reselect got=%b exp=%b", pll_in, last); end
  endtask

  task automatic test_async_reset();
    int k = 0;
    swipt_alive = 1'b1; pll_error = 2'b00;
    while (locked !== 1'b1 && k < 700) begin tick(); k++; end
    repeat (10) tick();
    checks++;
    if (state !== StTrack) begin failures++; $display("FAIL pre_reset got=%0d exp=3", state); end
    #2;
    nrst = 1'b0;
    model_reset();
    #1;
    checks++;
    if (outs !== ResetOuts) begin
      failures++; $display("FAIL async_reset got=%h exp=%h", outs, ResetOuts);
    end
    tick();
    nrst = 1'b1;
    swipt_alive = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_lock();
    test_unlock();
    test_timeout_tie();
    test_retry();
    test_drop();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
